lift_call_scheduler: RTL
========================

# lift_call_scheduler

Call scheduler sitting in front of the lift controller: latches floor calls from hall/cabin buttons into a pending-call bitmap and issues one target floor at a time to the controller's requested-floor input, using SCAN (collective) ordering. Arrival is detected from the controller's current-floor and stop outputs. Arrival clears the served call and opens a door-dwell window before the next target is issued.

## Interface
- NUM_FLOORS, 16, number of served floors (2..128)
- FLOOR_W, 7, floor-number width; matches the controller's floor bus
- DWELL_CYCLES, 4, door-hold length in clk cycles (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- call_valid  in  1  one floor call this cycle
- call_floor  in  FLOOR_W  floor being called
- cur_floor  in  FLOOR_W  current floor from lift controller
- lift_stop  in  1  lift halted at cur_floor (controller stop indication)
- target_floor  out  FLOOR_W  floor to drive into the controller's requested-floor input
- target_valid  out  1  target_floor is a live request
- dir_up  out  1  current sweep direction (1 = up)
- dwell  out  1  door-hold window active
- pending  out  NUM_FLOORS  registered pending-call bitmap, bit i = floor i
- call_err  out  1  one-cycle pulse: call_floor ≥ NUM_FLOORS, call dropped

## Operation
- Reset values: pending=0, state IDLE, target_floor=0, target_valid=0, dir_up=0, dwell=0, call_err=0, dwell counter=0. Reset mid-operation discards all pending calls.
- States: IDLE, SCAN_UP, SCAN_DOWN, DWELL.
- Call capture (any state): valid, in-range call sets pending[call_floor]. Duplicate calls are idempotent.
- IDLE: pending==0 → stay, target_valid=0. Otherwise: any pending floor ≥ cur_floor → SCAN_UP, dir_up=1; else SCAN_DOWN, dir_up=0.
- SCAN_UP: target = lowest pending floor ≥ cur_floor. If none: any pending → SCAN_DOWN; else → IDLE.
- SCAN_DOWN: target = highest pending floor ≤ cur_floor. If none: any pending → SCAN_UP; else → IDLE.
- Target update: a newly latched call between cur_floor and the current target, in the sweep direction, preempts the target on the next cycle.
- Arrival: in SCAN_UP/SCAN_DOWN with target_valid && lift_stop && cur_floor==target_floor:
  - clear pending[cur_floor]
  - go to DWELL; load counter with DWELL_CYCLES
  - dwell=1, target_valid=0
- DWELL:
  - Counter decrements each cycle. At 1 → return to the saved sweep state, which re-evaluates as above (direction may flip, or go to IDLE).
  - A call to cur_floor during DWELL is absorbed: not latched; counter reloads (door re-open).
  - Calls to other floors latch normally.
- Simultaneous arrival and call to the same floor: clear wins (call counts as served).
- Floor comparison is unsigned over FLOOR_W bits. Search covers only bits 0..NUM_FLOORS-1. No wrap-around: floor 0 and floor NUM_FLOORS-1 are hard ends.

## Timing
- Call latched on edge N → pending visible after N → target_floor/target_valid/dir_up updated after N+1 (2-cycle call-to-target latency from IDLE).
- All outputs registered; no combinational path from inputs to outputs.
- Arrival sampled on edge N → dwell=1, target_valid=0 after N. dwell stays high for exactly DWELL_CYCLES cycles absent re-open. The next target_valid is asserted 1 cycle after dwell falls.
- call_err asserted for the single cycle after the offending call edge.
- target_floor holds its last value while target_valid=0.

## Structure
- Shared package lift_pkg: state enum (IDLE, SCAN_UP, SCAN_DOWN, DWELL), default FLOOR_W, default NUM_FLOORS. The lift controller and scheduler both import it.
- Sub-module lift_scan_select: combinational search over pending and cur_floor. Outputs are up_hit/up_floor (lowest ≥ cur) and dn_hit/dn_floor (highest ≤ cur). The top holds the FSM, bitmap, dwell counter and output registers.

## Test plan
(NUM_FLOORS=16, DWELL_CYCLES=4)
- Reset held 2 cycles with call_valid=1 → all outputs 0, pending=0 after release.
- IDLE, cur=0, call 5 → pending=0x0020 next cycle; target_floor=5, target_valid=1, dir_up=1 one cycle later.
- cur=4 sweeping up, pending {2,6,9} → target 6. Arrival at 6 → dwell for 4 cycles, pending {2,9}, then target 9. Arrival at 9 → after dwell, dir_up=0, target 2. Arrival at 2 → IDLE, pending=0.
- Target 9 sweeping up at cur=3, call 5 → target becomes 5 two cycles after the call; floor 9 stays pending.
- call_floor=20 → call_err pulses 1 cycle, pending unchanged.
- DWELL at floor 6 on cycle 2, call 6 → pending bit 6 stays 0, dwell extends to 4 cycles from the re-open. Separately, reset asserted mid-DWELL with pending {3,12} → all outputs and pending 0 after the reset edge.

Source files
------------

// File: rtl/lift_pkg.sv
// ---------------------------------------------------------------------------
// lift_pkg
// Shared definitions for the lift controller and the call scheduler:
// scheduler state encoding and default bus/bitmap sizes.
// ---------------------------------------------------------------------------
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN_UP   = 2'd1,
        ST_SCAN_DOWN = 2'd2,
        ST_DWELL     = 2'd3
    } lift_state_e;

    localparam int LIFT_FLOOR_W      = 7;
    localparam int LIFT_NUM_FLOORS   = 16;
    localparam int LIFT_DWELL_CYCLES = 4;

endpackage

// File: rtl/lift_scan_select.sv
// ---------------------------------------------------------------------------
// lift_scan_select
// Combinational search of the pending-call bitmap relative to the current
// floor, one result per sweep direction.
//   pending_i    pending-call bitmap, bit i = floor i
//   cur_floor_i  current floor of the car
//   up_hit_o     some pending floor >= cur_floor_i
//   up_floor_o   lowest pending floor >= cur_floor_i
//   dn_hit_o     some pending floor <= cur_floor_i
//   dn_floor_o   highest pending floor <= cur_floor_i
// ---------------------------------------------------------------------------
module lift_scan_select
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = LIFT_NUM_FLOORS,
    parameter int FLOOR_W    = LIFT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    output logic                  up_hit_o,
    output logic [FLOOR_W-1:0]    up_floor_o,
    output logic                  dn_hit_o,
    output logic [FLOOR_W-1:0]    dn_floor_o
);

    // Upward search walks from the top so the last match is the lowest;
    // downward search walks from the bottom so the last match is the highest.
    always_comb begin
        up_hit_o   = 1'b0;
        up_floor_o = '0;
        dn_hit_o   = 1'b0;
        dn_floor_o = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && (i >= int'(cur_floor_i))) begin
                up_hit_o   = 1'b1;
                up_floor_o = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (i <= int'(cur_floor_i))) begin
                dn_hit_o   = 1'b1;
                dn_floor_o = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// ---------------------------------------------------------------------------
// lift_call_scheduler
// Latches floor calls into a pending bitmap and issues one target floor at a
// time to the lift controller in SCAN (collective) order, with a door-dwell
// window after each arrival.
//   clk_i / reset_i   clock, synchronous active-high reset
//   call_valid_i      one floor call this cycle, floor on call_floor_i
//   cur_floor_i       current floor from the lift controller
//   lift_stop_i       car halted at cur_floor_i
//   target_floor_o    requested floor for the controller (held while invalid)
//   target_valid_o    target_floor_o is a live request
//   dir_up_o          current sweep direction (1 = up)
//   dwell_o           door-hold window active
//   pending_o         pending-call bitmap, bit i = floor i
//   call_err_o        one-cycle pulse: out-of-range call dropped
//
// state        | meaning
// ST_IDLE      | no pending calls, no live target
// ST_SCAN_UP   | serving lowest pending floor >= current floor
// ST_SCAN_DOWN | serving highest pending floor <= current floor
// ST_DWELL     | doors held open; returns to the saved sweep state
// ---------------------------------------------------------------------------
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS   = LIFT_NUM_FLOORS,
    parameter int FLOOR_W      = LIFT_FLOOR_W,
    parameter int DWELL_CYCLES = LIFT_DWELL_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  call_valid_i,
    input  logic [FLOOR_W-1:0]    call_floor_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  logic                  lift_stop_i,
    output logic [FLOOR_W-1:0]    target_floor_o,
    output logic                  target_valid_o,
    output logic                  dir_up_o,
    output logic                  dwell_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  call_err_o
);

    localparam int               CNT_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES);

    lift_state_e           state_q;
    lift_state_e           saved_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] clr_vec;
    logic [FLOOR_W-1:0]    target_floor_q;
    logic                  target_valid_q;
    logic                  dir_up_q;
    logic                  dwell_q;
    logic                  call_err_q;
    logic [CNT_W-1:0]      dwell_cnt_q;

    logic                  up_hit;
    logic                  dn_hit;
    logic [FLOOR_W-1:0]    up_floor;
    logic [FLOOR_W-1:0]    dn_floor;
    logic                  in_range;
    logic                  absorb;
    logic                  arrive;
    logic                  go_up;
    logic                  go_dn;

    lift_scan_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending_i   (pending_q),
        .cur_floor_i (cur_floor_i),
        .up_hit_o    (up_hit),
        .up_floor_o  (up_floor),
        .dn_hit_o    (dn_hit),
        .dn_floor_o  (dn_floor)
    );

    always_comb begin
        in_range = call_valid_i && (int'(call_floor_i) < NUM_FLOORS);
        // A call for the floor the doors are open at re-opens them instead
        // of becoming a new pending call.
        absorb   = in_range && (state_q == ST_DWELL) && (call_floor_i == cur_floor_i);
        arrive   = ((state_q == ST_SCAN_UP) || (state_q == ST_SCAN_DOWN)) &&
                   target_valid_q && lift_stop_i && (cur_floor_i == target_floor_q);
        for (int i = 0; i < NUM_FLOORS; i++) begin
            set_vec[i] = in_range && !absorb && (int'(call_floor_i) == i);
            clr_vec[i] = arrive && (int'(cur_floor_i) == i);
        end
        // Clear after set: a call arriving with the car at that floor is served.
        pending_d = (pending_q | set_vec) & ~clr_vec;

        // IDLE and SCAN_UP both prefer the upward sweep; SCAN_DOWN prefers
        // downward. When the preferred side is empty the sweep flips and the
        // opposite target is issued in the same cycle.
        if (state_q == ST_SCAN_DOWN) begin
            go_dn = dn_hit;
            go_up = !dn_hit && up_hit;
        end else begin
            go_up = up_hit;
            go_dn = !up_hit && dn_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            saved_q        <= ST_IDLE;
            pending_q      <= '0;
            target_floor_q <= '0;
            target_valid_q <= 1'b0;
            dir_up_q       <= 1'b0;
            dwell_q        <= 1'b0;
            call_err_q     <= 1'b0;
            dwell_cnt_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            call_err_q <= call_valid_i && !in_range;
            case (state_q)
                ST_DWELL: begin
                    if (absorb) begin
                        dwell_cnt_q <= CNT_LOAD;
                    end else if (dwell_cnt_q == CNT_W'(1)) begin
                        state_q     <= saved_q;
                        dwell_q     <= 1'b0;
                        dwell_cnt_q <= '0;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (arrive) begin
                        saved_q        <= state_q;
                        state_q        <= ST_DWELL;
                        dwell_q        <= 1'b1;
                        target_valid_q <= 1'b0;
                        dwell_cnt_q    <= CNT_LOAD;
                    end else if (go_up) begin
                        state_q        <= ST_SCAN_UP;
                        dir_up_q       <= 1'b1;
                        target_floor_q <= up_floor;
                        target_valid_q <= 1'b1;
                    end else if (go_dn) begin
                        state_q        <= ST_SCAN_DOWN;
                        dir_up_q       <= 1'b0;
                        target_floor_q <= dn_floor;
                        target_valid_q <= 1'b1;
                    end else begin
                        state_q        <= ST_IDLE;
                        target_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign target_floor_o = target_floor_q;
    assign target_valid_o = target_valid_q;
    assign dir_up_o       = dir_up_q;
    assign dwell_o        = dwell_q;
    assign pending_o      = pending_q;
    assign call_err_o     = call_err_q;

endmodule
